decoder_route_scheduler: RTL and testbench



---
 rtl/decoder_route_scheduler.sv | 142 ++++++++++++++
 tb/tb_decoder_route_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/decoder_route_scheduler.sv
// Sequencer for the 1-to-4 routing decoder: queues (dest, bit) requests in a FIFO
// and drives each onto the decoder for HOLD cycles, followed by a one-cycle gap.
module decoder_route_scheduler #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned HOLD  = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [1:0]       wr_dest,
   input  logic             wr_bit,
   output logic             dec_in,
   output logic [1:0]       dec_sel,
   output logic             dec_en,
   output logic             done_pulse,
   output logic             busy,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned HC_W  = $clog2(HOLD + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_ready_q, wr_ready_d;
   logic             dec_in_q, dec_in_d;
   logic [1:0]       dec_sel_q, dec_sel_d;
   logic             dec_en_q, dec_en_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic [2:0]       mem_q [DEPTH];

   logic             push;
   logic             pop;
   logic [2:0]       head;

   assign push = wr_valid & wr_ready_q;
   assign head = mem_q[rd_ptr_q];

   // Next-state and next-output logic; a pop happens only on entry into DRIVE
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      dec_in_d   = 1'b0;
      dec_sel_d  = dec_sel_q;
      dec_en_d   = 1'b0;
      done_d     = 1'b0;
      pop        = 1'b0;

      case (state_q)
         ST_IDLE, ST_GAP: begin
            if (count_q != '0) begin
               pop        = 1'b1;
               state_d    = ST_DRIVE;
               dec_sel_d  = head[2:1];
               dec_in_d   = head[0];
               dec_en_d   = 1'b1;
               hold_cnt_d = HC_W'(HOLD - 1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (hold_cnt_q != '0) begin
               hold_cnt_d = hold_cnt_q - HC_W'(1);
               dec_in_d   = dec_in_q;
               dec_en_d   = 1'b1;
            end else begin
               state_d = ST_GAP;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Ready follows occupancy only, so a pop while full cannot bypass
      wr_ready_d = (count_d < CNT_W'(DEPTH));
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         wr_ready_q <= 1'b1;
         dec_in_q   <= 1'b0;
         dec_sel_q  <= 2'd0;
         dec_en_q   <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wr_ready_q <= wr_ready_d;
         dec_in_q   <= dec_in_d;
         dec_sel_q  <= dec_sel_d;
         dec_en_q   <= dec_en_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   // FIFO storage; stale slots are harmless because pointers reset
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= {wr_dest, wr_bit};
      end
   end

   assign wr_ready   = wr_ready_q;
   assign dec_in     = dec_in_q;
   assign dec_sel    = dec_sel_q;
   assign dec_en     = dec_en_q;
   assign done_pulse = done_q;
   assign busy       = busy_q;
   assign count      = count_q;

endmodule

// File: tb/tb_decoder_route_scheduler.sv
// Bench for decoder_route_scheduler: two instances (HOLD=2 and HOLD=1) share stimulus
// and are each checked every cycle against a queue-plus-timeline reference model.
module tb_decoder_route_scheduler;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_valid;
   logic [1:0] wr_dest;
   logic       wr_bit;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int unsigned H = (g == 0) ? 2 : 1;

      logic             wr_ready;
      logic             dec_in;
      logic [1:0]       dec_sel;
      logic             dec_en;
      logic             done_pulse;
      logic             busy;
      logic [CNT_W-1:0] count;

      decoder_route_scheduler #(.DEPTH(DEPTH), .HOLD(H)) u_dut (
         .clk        (clk),
         .reset      (reset),
         .wr_valid   (wr_valid),
         .wr_ready   (wr_ready),
         .wr_dest    (wr_dest),
         .wr_bit     (wr_bit),
         .dec_in     (dec_in),
         .dec_sel    (dec_sel),
         .dec_en     (dec_en),
         .done_pulse (done_pulse),
         .busy       (busy),
         .count      (count)
      );

      // Model: pending entries in a queue; the active route is a window of cycles
      logic [2:0] mq [$];
      int         cyc     = 0;
      int         free_at = 0;
      int         m_start = -1000;
      logic [1:0] m_sel   = 2'd0;
      logic       m_bit   = 1'b0;

      always @(posedge clk) begin
         logic [2:0] e;
         bit         do_pop;
         bit         do_push;
         bit         x_en;
         bit         x_busy;
         bit         x_done;
         string      p;
         if (reset) begin
            mq.delete();
            m_start = -1000;
            free_at = 0;
            m_sel   = 2'd0;
            m_bit   = 1'b0;
         end else begin
            do_pop  = (mq.size() > 0) && (cyc >= free_at);
            do_push = wr_valid && (mq.size() < DEPTH);
            if (do_pop) begin
               e       = mq.pop_front();
               m_sel   = e[2:1];
               m_bit   = e[0];
               m_start = cyc + 1;
               free_at = cyc + int'(H) + 1;
            end
            if (do_push) mq.push_back({wr_dest, wr_bit});
         end
         cyc++;
         #1;
         x_en   = (cyc >= m_start) && (cyc < m_start + int'(H));
         x_done = (cyc == m_start + int'(H));
         x_busy = (cyc >= m_start) && (cyc <= m_start + int'(H));
         p = $sformatf("hold%0d", H);
         check_eq({p, ".dec_en"},     32'(dec_en),     32'(x_en));
         check_eq({p, ".dec_in"},     32'(dec_in),     32'(x_en & m_bit));
         check_eq({p, ".dec_sel"},    32'(dec_sel),    32'(m_sel));
         check_eq({p, ".done_pulse"}, 32'(done_pulse), 32'(x_done));
         check_eq({p, ".busy"},       32'(busy),       32'(x_busy));
         check_eq({p, ".count"},      32'(count),      32'(mq.size()));
         check_eq({p, ".wr_ready"},   32'(wr_ready),   32'(mq.size() < DEPTH));
      end
   end

   task automatic drive(input logic v, input logic [1:0] d, input logic b, input logic r);
      @(negedge clk);
      wr_valid = v;
      wr_dest  = d;
      wr_bit   = b;
      reset    = r;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   logic [1:0] seq_dest [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
   logic       seq_bit  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      int idx;
      int guard;
      int density;
      reset    = 1'b1;
      wr_valid = 1'b0;
      wr_dest  = 2'd0;
      wr_bit   = 1'b0;
      repeat (2) @(posedge clk);
      idle(6);

      // single route, dest 2 bit 1
      drive(1'b1, 2'd2, 1'b1, 1'b0);
      idle(8);

      // seven back-to-back requests, held until accepted by the HOLD=2 instance
      idx   = 0;
      guard = 0;
      while (idx < 7 && guard < 200) begin
         drive(1'b1, seq_dest[idx], seq_bit[idx], 1'b0);
         if (g_lane[0].wr_ready) idx++;
         guard++;
      end
      if (idx < 7) check_eq("push_timeout.wr_ready", 32'(g_lane[0].wr_ready), 32'd1);
      idle(30);

      // reset lands while a route is being driven, with a request in the same cycle
      drive(1'b1, 2'd1, 1'b1, 1'b0);
      idle(2);
      drive(1'b1, 2'd3, 1'b1, 1'b1);
      idle(10);

      // three routes to dest 3
      for (int i = 0; i < 3; i++) drive(1'b1, 2'd3, 1'b1, 1'b0);
      idle(15);

      // randomized traffic at several densities with occasional resets
      for (int seg = 0; seg < 4; seg++) begin
         density = (seg == 0) ? 20 : (seg == 1) ? 50 : (seg == 2) ? 90 : 100;
         for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < density) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
         end
      end
      idle(20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
